w_mem_access_ctrl: RTL

- Sequences and arbitrates the weight-memory SRAM wrapper (single rd/wr port pair, 1-cycle synchronous read latency, write has priority inside the wrapper).
- Shares the memory between a weight loader (write stream, valid/ready) and a compute-side read streamer that walks a strided address range and delivers words to the PE array through a 2-entry output buffer.
- Sits between the loader/DMA, the PE-array weight feed, and the weight SRAM wrapper.

---
 rtl/w_mem_access_ctrl_pkg.sv | 34 +++
 rtl/w_mem_access_ctrl_if.sv | 60 ++++++
 rtl/w_mem_skid_fifo.sv | 64 ++++++
 rtl/w_mem_access_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/w_mem_access_ctrl_pkg.sv
// Shared definitions for the weight-memory access controller.
// The word width and address width are built up from the SRAM wrapper's
// physical organisation so that a change there propagates automatically.
// Also holds the controller state enum and the arbitration-winner enum.
package w_mem_pkg;

  // A word is formed by four 8-bit SRAM blocks side by side.
  localparam int BYTE_W          = 8;
  localparam int BLOCKS_PER_WORD = 4;

  // Word address = row (10) + column select (2) + bank (1) + block group (2).
  localparam int ROW_AW   = 10;
  localparam int COL_AW   = 2;
  localparam int BANK_AW  = 1;
  localparam int GROUP_AW = 2;

  localparam int DEF_DATA_W   = BLOCKS_PER_WORD * BYTE_W;
  localparam int DEF_ADDR_W   = ROW_AW + COL_AW + BANK_AW + GROUP_AW;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_STRIDE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } ctrl_state_e;

  // Side that won the most recent read/write conflict.
  typedef enum logic {
    ARB_READ  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_win_e;

endpackage

// File: rtl/w_mem_access_ctrl_if.sv
// Bus bundle for w_mem_access_ctrl: burst control, loader write stream,
// PE-array output stream and the weight SRAM wrapper port pair.
//   master : the surroundings (sequencer, loader, PE array, SRAM wrapper)
//   slave  : the controller itself
interface w_mem_access_ctrl_if
  import w_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int STRIDE_W = DEF_STRIDE_W
);

  // burst control
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [CNT_W-1:0]    burst_len;
  logic [STRIDE_W-1:0] stride;
  logic                abort;
  logic                busy;
  logic                done;

  // loader write stream
  logic                ld_valid;
  logic [ADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_ready;

  // PE-array read stream
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_ready;

  // SRAM wrapper
  logic                mem_rd_enable;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [DATA_W-1:0]   mem_rd_data;
  logic                mem_wr_enable;
  logic [ADDR_W-1:0]   mem_wr_addr;
  logic [DATA_W-1:0]   mem_wr_data;

  modport master (
    output start, base_addr, burst_len, stride, abort,
    output ld_valid, ld_addr, ld_data,
    output out_ready,
    output mem_rd_data,
    input  busy, done, ld_ready, out_valid, out_data,
    input  mem_rd_enable, mem_rd_addr, mem_wr_enable, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  start, base_addr, burst_len, stride, abort,
    input  ld_valid, ld_addr, ld_data,
    input  out_ready,
    input  mem_rd_data,
    output busy, done, ld_ready, out_valid, out_data,
    output mem_rd_enable, mem_rd_addr, mem_wr_enable, mem_wr_addr, mem_wr_data
  );

endinterface

// File: rtl/w_mem_skid_fifo.sv
// Two-entry output buffer between the SRAM read port and the PE array.
// Ports:
//   clk, reset          clock, async active-low reset
//   flush               empty the buffer (wins over push/pop)
//   push, push_data     write one word
//   pop                 consume the head word (ignored when empty)
//   valid, head, count  not-empty flag, head word, occupancy 0..2
// Push and pop in the same cycle are allowed, including when full.
module w_mem_skid_fifo
  import w_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign valid = (count_q != 2'd0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/w_mem_access_ctrl.sv
// Weight-memory access controller. Shares the single-port-pair weight SRAM
// wrapper between the loader write stream and a strided read burst feeding
// the PE array through a 2-entry output buffer.
// Ports:
//   clk    clock
//   reset  async active-low reset
//   bus    w_mem_access_ctrl_if.slave: burst control (start/abort/busy/done),
//          loader stream (ld_*), PE stream (out_*), SRAM port pair (mem_*)
// Usage rule: the loader and the read burst must target disjoint address
// ranges while a burst runs; there is no read-after-write hazard check.
//
// state  | meaning
// IDLE   | no burst; accepts start
// STREAM | issuing reads while words remain and the buffer has room
// DRAIN  | all reads issued; waiting for the buffer to empty, then done
module w_mem_access_ctrl
  import w_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int STRIDE_W = DEF_STRIDE_W
) (
  input  logic               clk,
  input  logic               reset,
  w_mem_access_ctrl_if.slave bus
);

  ctrl_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic                inflight_q;
  arb_win_e            rr_last_q;

  logic                abort_act;
  logic                rd_elig;
  logic                wr_elig;
  logic                conflict;
  logic                grant_rd;
  logic                grant_wr;
  logic                done_c;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_valid;
  logic [DATA_W-1:0]   fifo_head;
  logic [1:0]          fifo_count;
  logic [1:0]          pending;

  assign abort_act = bus.abort && (state_q != IDLE);

  // Words held or on their way, after this cycle's pop. Counting the pop
  // keeps one read per cycle going when the PE array never stalls.
  assign fifo_pop = fifo_valid && bus.out_ready;
  assign pending  = fifo_count + {1'b0, inflight_q} - {1'b0, fifo_pop};

  assign rd_elig = (state_q == STREAM) && (remaining_q != '0) &&
                   (pending < 2'd2) && !abort_act;
  // Gated by reset so the combinational write grant is also 0 in reset.
  assign wr_elig = bus.ld_valid && reset;

  // On a conflict the side that lost the previous conflict wins.
  assign conflict = rd_elig && wr_elig;
  assign grant_wr = wr_elig && (!rd_elig || (rr_last_q == ARB_READ));
  assign grant_rd = rd_elig && !grant_wr;

  // A read in flight during an abort still returns; it is simply not kept.
  assign fifo_push = inflight_q && !abort_act;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    stride_d    = stride_q;
    done_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cur_addr_d  = bus.base_addr;
          remaining_d = bus.burst_len;
          stride_d    = bus.stride;
          state_d     = (bus.burst_len == '0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (abort_act) begin
          state_d = IDLE;
        end else if (grant_rd) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(stride_q);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort_act) begin
          state_d = IDLE;
        end else if ((fifo_count == 2'd0) && !inflight_q) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      stride_q    <= '0;
      inflight_q  <= 1'b0;
      rr_last_q   <= ARB_READ;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      stride_q    <= stride_d;
      inflight_q  <= grant_rd;
      if (conflict) begin
        rr_last_q <= grant_wr ? ARB_WRITE : ARB_READ;
      end
    end
  end

  w_mem_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort_act),
    .push      (fifo_push),
    .push_data (bus.mem_rd_data),
    .pop       (fifo_pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_c;
  assign bus.out_valid     = fifo_valid;
  assign bus.out_data      = fifo_head;
  assign bus.ld_ready      = grant_wr;
  assign bus.mem_rd_enable = grant_rd;
  assign bus.mem_rd_addr   = grant_rd ? cur_addr_q : '0;
  assign bus.mem_wr_enable = grant_wr;
  assign bus.mem_wr_addr   = grant_wr ? bus.ld_addr : '0;
  assign bus.mem_wr_data   = grant_wr ? bus.ld_data : '0;

endmodule
